pattern_sequencer: RTL and testbench

Frame-synchronous test-pattern controller for the VGA test-pattern path. It selects one of four patterns and computes the 12-bit pixel colour from the current pixel coordinates. It sits between the timing/coordinate outputs of the VGA core and the core's `color` input. Pattern changes come from a debounced push-button or an automatic frame timer, and take effect only on frame boundaries, so a frame is never torn.

---
 rtl/pattern_sequencer.sv | 156 +++++++++++++++
 tb/tb_pattern_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - frame-synchronous VGA test-pattern selector and pixel colour generator
module pattern_sequencer #(
    parameter int H_ACTIVE        = 1280,
    parameter int V_ACTIVE        = 720,
    parameter int AUTO_FRAMES     = 120,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic        clk_dot,
    input  logic        reset,
    input  logic        vid_new_frame,
    input  logic        vga_active,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        btn_next,
    input  logic        auto_en,
    output logic [11:0] color,
    output logic [1:0]  pattern_id,
    output logic        pattern_changed
);

    localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [11:0]     AUTO_MAX = 12'(AUTO_FRAMES - 1);
    localparam int              BAR_W    = H_ACTIVE / 8;
    localparam logic [11:0]     B1       = 12'(BAR_W);
    localparam logic [11:0]     B2       = 12'(2 * BAR_W);
    localparam logic [11:0]     B3       = 12'(3 * BAR_W);
    localparam logic [11:0]     B4       = 12'(4 * BAR_W);
    localparam logic [11:0]     B5       = 12'(5 * BAR_W);
    localparam logic [11:0]     B6       = 12'(6 * BAR_W);
    localparam logic [11:0]     B7       = 12'(7 * BAR_W);
    localparam logic [11:0]     X_LIM    = 12'(H_ACTIVE);
    localparam logic [10:0]     Y_LIM    = 11'(V_ACTIVE);
    localparam logic [11:0]     X_LAST   = 12'(H_ACTIVE - 1);
    localparam logic [10:0]     Y_LAST   = 11'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        BARS     = 2'd0,
        GRID     = 2'd1,
        CHECKER  = 2'd2,
        GRADIENT = 2'd3
    } pattern_t;

    pattern_t        state_q, state_d;
    logic            sync1, sync2;
    logic            db_level, db_level_d;
    logic [DB_W-1:0] db_cnt;
    logic            pending;
    logic [11:0]     frame_cnt;
    logic            db_rise, auto_hit, advance;
    logic [11:0]     pix_color;
    logic [11:0]     xw;
    logic [10:0]     yw;

    assign xw = {1'b0, x};
    assign yw = {1'b0, y};

    // The debounce counter only runs while the synchronized input disagrees with the accepted level
    always_ff @(posedge clk_dot or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            db_level   <= 1'b0;
            db_level_d <= 1'b0;
            db_cnt     <= '0;
        end else begin
            sync1      <= btn_next;
            sync2      <= sync1;
            db_level_d <= db_level;
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                db_level <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign db_rise  = db_level & ~db_level_d;
    assign auto_hit = vid_new_frame & auto_en & (frame_cnt == AUTO_MAX);
    assign advance  = vid_new_frame & (pending | auto_hit);

    // A rise on the consuming cycle re-arms pending so that press is shown next frame
    always_ff @(posedge clk_dot or posedge reset) begin
        if (reset) begin
            pending   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            pending <= (pending & ~advance) | db_rise;
            if (!auto_en || advance) begin
                frame_cnt <= '0;
            end else if (vid_new_frame) begin
                frame_cnt <= frame_cnt + 12'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = pattern_t'(state_q + 2'd1);
        end
    end

    always_ff @(posedge clk_dot or posedge reset) begin
        if (reset) begin
            state_q         <= BARS;
            pattern_changed <= 1'b0;
        end else begin
            state_q         <= state_d;
            pattern_changed <= advance;
        end
    end

    assign pattern_id = state_q;

    always_comb begin
        pix_color = 12'h000;
        if (vga_active && (xw < X_LIM) && (yw < Y_LIM)) begin
            case (state_q)
                BARS: begin
                    if      (xw < B1) pix_color = 12'hFFF;
                    else if (xw < B2) pix_color = 12'hFF0;
                    else if (xw < B3) pix_color = 12'h0FF;
                    else if (xw < B4) pix_color = 12'h0F0;
                    else if (xw < B5) pix_color = 12'hF0F;
                    else if (xw < B6) pix_color = 12'hF00;
                    else if (xw < B7) pix_color = 12'h00F;
                    else              pix_color = 12'h000;
                end
                GRID: begin
                    if ((x[4:0] == 5'd0) || (y[4:0] == 5'd0) || (xw == X_LAST) || (yw == Y_LAST))
                        pix_color = 12'hFFF;
                end
                CHECKER: begin
                    if (x[5] ^ y[5]) pix_color = 12'hFFF;
                end
                GRADIENT: begin
                    pix_color = {x[7:4], y[7:4], ~x[7:4]};
                end
                default: pix_color = 12'h000;
            endcase
        end
    end

    always_ff @(posedge clk_dot or posedge reset) begin
        if (reset) begin
            color <= 12'h000;
        end else begin
            color <= pix_color;
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - randomized self-checking bench for pattern_sequencer
module tb_pattern_sequencer;

    localparam int H  = 1280;
    localparam int V  = 720;
    localparam int AF = 3;
    localparam int DB = 4;

    logic        clk_dot = 1'b0;
    logic        reset = 1'b1;
    logic        vid_new_frame = 1'b0;
    logic        vga_active = 1'b0;
    logic [10:0] x = '0;
    logic [9:0]  y = '0;
    logic        btn_next = 1'b0;
    logic        auto_en = 1'b0;
    logic [11:0] color;
    logic [1:0]  pattern_id;
    logic        pattern_changed;

    pattern_sequencer #(
        .H_ACTIVE(H), .V_ACTIVE(V), .AUTO_FRAMES(AF), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk_dot(clk_dot), .reset(reset), .vid_new_frame(vid_new_frame),
        .vga_active(vga_active), .x(x), .y(y), .btn_next(btn_next),
        .auto_en(auto_en), .color(color), .pattern_id(pattern_id),
        .pattern_changed(pattern_changed)
    );

    always #5 clk_dot = ~clk_dot;

    int n_checks = 0;
    int n_errs   = 0;
    int n_pulses = 0;

    logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    // reference state
    int          m_s1 = 0, m_s2 = 0, m_level = 0, m_level_prev = 0, m_run = 0;
    int          m_pending = 0, m_fcnt = 0, m_pid = 0;
    logic [11:0] m_color = '0;
    int          m_changed = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_color(input int xi, input int yi, input bit act, input int pid);
        logic [3:0] r, g;
        if (!act || xi >= H || yi >= V) return 12'h000;
        case (pid)
            0: return bar_tab[xi / (H / 8)];
            1: return (xi % 32 == 0 || yi % 32 == 0 || xi == H - 1 || yi == V - 1) ? 12'hFFF : 12'h000;
            2: return ((((xi / 32) ^ (yi / 32)) % 2) == 1) ? 12'hFFF : 12'h000;
            default: begin
                r = 4'((xi / 16) % 16);
                g = 4'((yi / 16) % 16);
                return {r, g, 4'(15 - int'(r))};
            end
        endcase
    endfunction

    // Reference: button accepted after DB consecutive disagreeing samples; frame-gated advance
    always @(posedge clk_dot or posedge reset) begin
        int rise, hit, adv;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_level_prev = 0; m_run = 0;
            m_pending = 0; m_fcnt = 0; m_pid = 0; m_color = '0; m_changed = 0;
        end else begin
            rise = (m_level == 1 && m_level_prev == 0) ? 1 : 0;
            hit  = (vid_new_frame && auto_en && m_fcnt == AF - 1) ? 1 : 0;
            adv  = (vid_new_frame && (m_pending == 1 || hit == 1)) ? 1 : 0;
            m_color   = exp_color(int'(x), int'(y), vga_active, m_pid);
            m_changed = adv;
            if (adv == 1) m_pid = (m_pid + 1) % 4;
            m_pending = ((m_pending == 1 && adv == 0) || rise == 1) ? 1 : 0;
            if (!auto_en || adv == 1) m_fcnt = 0;
            else if (vid_new_frame) m_fcnt = m_fcnt + 1;
            m_level_prev = m_level;
            if (m_s2 != m_level) begin
                m_run = m_run + 1;
                if (m_run == DB) begin
                    m_level = m_s2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = int'(btn_next);
        end
    end

    always @(negedge clk_dot) begin
        chk("color", int'(color), int'(m_color));
        chk("pattern_id", int'(pattern_id), m_pid);
        chk("pattern_changed", int'(pattern_changed), m_changed);
        if (pattern_changed) n_pulses++;
    end

    task automatic idle_pix();
        @(negedge clk_dot);
        vid_new_frame = 1'b0;
        vga_active = ($urandom_range(0, 3) != 0);
        x = 11'($urandom_range(0, 1400));
        y = 10'($urandom_range(0, 800));
    endtask

    task automatic cycles(input int n);
        repeat (n) idle_pix();
    endtask

    task automatic frame();
        @(negedge clk_dot);
        vid_new_frame = 1'b1;
        vga_active = 1'b0;
        x = '0;
        y = '0;
        cycles(4);
    endtask

    task automatic press(input int len);
        @(negedge clk_dot);
        btn_next = 1'b1;
        cycles(len);
        btn_next = 1'b0;
        cycles(DB + 8);
    endtask

    initial begin
        int p0;
        repeat (3) @(negedge clk_dot);
        chk("reset_color", int'(color), 0);
        chk("reset_id", int'(pattern_id), 0);
        chk("reset_changed", int'(pattern_changed), 0);
        reset = 1'b0;

        // one active line of BARS
        for (int i = 0; i <= H; i++) begin
            @(negedge clk_dot);
            if (i == 1)    chk("bar_x0", int'(color), 12'hFFF);
            if (i == 161)  chk("bar_x160", int'(color), 12'hFF0);
            if (i == 1121) chk("bar_x1120", int'(color), 12'h000);
            vga_active = (i < H);
            y = 10'd5;
            x = 11'(i % H);
        end
        @(negedge clk_dot);
        chk("blank_inactive", int'(color), 12'h000);

        // single press
        p0 = n_pulses;
        press(20);
        frame();
        chk("press_id", int'(pattern_id), 1);
        chk("press_pulses", n_pulses - p0, 1);

        // bouncing glitches only
        p0 = n_pulses;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_dot); btn_next = 1'b1;
            if (k % 2 == 1) @(negedge clk_dot);
            @(negedge clk_dot); btn_next = 1'b0;
            cycles(3);
        end
        cycles(DB + 8);
        frame();
        chk("bounce_id", int'(pattern_id), 1);
        chk("bounce_pulses", n_pulses - p0, 0);

        // three presses in one frame collapse to one advance
        p0 = n_pulses;
        press(10); press(10); press(10);
        frame();
        frame();
        chk("multi_id", int'(pattern_id), 2);
        chk("multi_pulses", n_pulses - p0, 1);

        // one press per frame, with wrap
        press(12); frame(); chk("seq_id3", int'(pattern_id), 3);
        press(12); frame(); chk("seq_wrap0", int'(pattern_id), 0);
        press(12); frame(); chk("seq_id1", int'(pattern_id), 1);
        press(12); frame(); chk("seq_id2", int'(pattern_id), 2);

        // auto mode: advance on frames 3, 6, 9
        p0 = n_pulses;
        auto_en = 1'b1;
        for (int f = 1; f <= 9; f++) begin
            frame();
            if (f == 2) chk("auto_f2", n_pulses - p0, 0);
            if (f == 3) chk("auto_f3", n_pulses - p0, 1);
            if (f == 9) chk("auto_f9", n_pulses - p0, 3);
        end
        // drop auto_en, then re-enable: needs a full interval again
        p0 = n_pulses;
        frame(); frame();
        auto_en = 1'b0;
        frame(); frame(); frame();
        chk("auto_off", n_pulses - p0, 0);
        auto_en = 1'b1;
        frame(); frame();
        chk("auto_re2", n_pulses - p0, 0);
        frame();
        chk("auto_re3", n_pulses - p0, 1);

        // press pending on the frame auto_hit fires
        p0 = n_pulses;
        frame(); frame();
        press(12);
        frame();
        chk("simul_single", n_pulses - p0, 1);
        frame(); frame();
        chk("simul_cnt_clear", n_pulses - p0, 1);
        frame();
        chk("simul_next_auto", n_pulses - p0, 2);
        auto_en = 1'b0;

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_dot);
            vid_new_frame = ($urandom_range(0, 149) == 0);
            vga_active = ($urandom_range(0, 3) != 0);
            x = 11'($urandom_range(0, 1400));
            y = 10'($urandom_range(0, 800));
            if ($urandom_range(0, 7) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 499) == 0) auto_en = ~auto_en;
        end
        btn_next = 1'b0;
        auto_en = 1'b0;
        cycles(DB + 8);
        frame();

        // reach CHECKER with a press pending, then reset mid-frame
        for (int k = 0; k < 4 && m_pid != 2; k++) begin
            press(12);
            frame();
        end
        chk("pre_reset_id", int'(pattern_id), 2);
        press(12);
        @(negedge clk_dot);
        vga_active = 1'b1;
        x = 11'd32;
        y = 10'd0;
        @(posedge clk_dot);
        #1;
        chk("pre_reset_color", int'(color), 12'hFFF);
        #1;
        reset = 1'b1;
        #1;
        chk("async_color", int'(color), 0);
        chk("async_id", int'(pattern_id), 0);
        chk("async_changed", int'(pattern_changed), 0);
        repeat (2) @(negedge clk_dot);
        reset = 1'b0;
        p0 = n_pulses;
        frame();
        frame();
        chk("post_reset_id", int'(pattern_id), 0);
        chk("post_reset_pulses", n_pulses - p0, 0);

        @(negedge clk_dot);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
